// File: rtl/code_parse_stage_pkg.sv
// Shared definitions for the code parse stage: class encodings and default widths.
package code_parse_stage_pkg;

  // Default instruction code width and opcode field width.
  localparam int unsigned DEF_CODE_W = 16;
  localparam int unsigned DEF_OPC_W  = 4;

  // Width of the saturating accept counter.
  localparam int unsigned ACC_W = 16;

  // Per-entry metadata stored next to the raw code: {illegal, class}.
  localparam int unsigned META_W = 3;

  // Instruction class encodings as presented on out_class.
  typedef enum logic [1:0] {
    CLS_NOP  = 2'd0,
    CLS_ALU  = 2'd1,
    CLS_LDST = 2'd2,
    CLS_BR   = 2'd3
  } cls_e;

endpackage : code_parse_stage_pkg

// File: rtl/parse_fifo.sv
// Parse FIFO: DEPTH-entry ready/valid queue with registered status flags.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push_valid/ready  write handshake; push_ready is registered and never
//                     looks at pop_ready in the same cycle
//   push_data         entry to enqueue
//   pop_valid/ready   read handshake; pop_valid is registered (occupancy != 0)
//   pop_data          head entry, read straight from storage
//   full              registered, always the inverse of push_ready
module parse_fifo
  import code_parse_stage_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_CODE_W + META_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ready,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic             full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             push;
  logic             pop;

  assign push = push_valid && push_ready;
  assign pop  = pop_valid && pop_ready;

  // Next occupancy; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointers, occupancy and registered status flags. DEPTH is a power of
  // two, so the pointers wrap modulo DEPTH by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      push_ready <= 1'b0;
      full       <= 1'b1;
      pop_valid  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_d;
      push_ready <= (count_d < CNT_W'(DEPTH));
      full       <= (count_d == CNT_W'(DEPTH));
      pop_valid  <= (count_d != '0);
    end
  end

  // Storage carries no reset; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data = mem[rd_ptr_q];

endmodule : parse_fifo

// File: rtl/code_parse_stage.sv
// Code parse stage: decodes fetched instruction codes at push time and
// queues {illegal, class, code} for the downstream consumer.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        producer handshake, in_code is the raw code
//   back_pressure            inverse of in_ready
//   out_valid/out_ready      consumer handshake on the queue head
//   out_code/class/illegal   head entry fields (don't-care while !out_valid)
//   match_hit                one-cycle pulse after accepting MATCH_CODE
//   accept_cnt               saturating count of accepted codes
module code_parse_stage
  import code_parse_stage_pkg::*;
#(
  parameter int unsigned          CODE_W     = DEF_CODE_W,
  parameter int unsigned          OPC_W      = DEF_OPC_W,
  parameter int unsigned          DEPTH      = 4,
  parameter logic [CODE_W-1:0]    MATCH_CODE = CODE_W'(16'h0002)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  output logic              back_pressure,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [1:0]        out_class,
  output logic              out_illegal,
  output logic              match_hit,
  output logic [ACC_W-1:0]  accept_cnt
);

  localparam int unsigned ENT_W = CODE_W + META_W;

  logic [OPC_W-1:0] opc;
  cls_e             dec_cls;
  logic             dec_ill;
  logic             push;
  logic [ENT_W-1:0] push_data;
  logic [ENT_W-1:0] pop_data;

  assign push = in_valid && in_ready;

  // Decode of the incoming code; an all-ones opcode is illegal and treated as NOP.
  always_comb begin
    opc     = in_code[CODE_W-1 -: OPC_W];
    dec_cls = CLS_NOP;
    dec_ill = 1'b0;
    if (in_code == '0) begin
      dec_cls = CLS_NOP;
    end else if (&opc) begin
      dec_cls = CLS_NOP;
      dec_ill = 1'b1;
    end else if (!opc[OPC_W-1]) begin
      dec_cls = CLS_ALU;
    end else if (!opc[OPC_W-2]) begin
      dec_cls = CLS_LDST;
    end else begin
      dec_cls = CLS_BR;
    end
  end

  assign push_data = {dec_ill, 2'(dec_cls), in_code};

  parse_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (in_valid),
    .push_data  (push_data),
    .push_ready (in_ready),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (pop_data),
    .full       (back_pressure)
  );

  assign out_code    = pop_data[CODE_W-1:0];
  assign out_class   = pop_data[CODE_W +: 2];
  assign out_illegal = pop_data[CODE_W + 2];

  // Match pulse and saturating accept counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_hit  <= 1'b0;
      accept_cnt <= '0;
    end else begin
      match_hit <= push && (in_code == MATCH_CODE);
      if (push && (accept_cnt != '1)) begin
        accept_cnt <= accept_cnt + ACC_W'(1);
      end
    end
  end

endmodule : code_parse_stage

// File: tb/tb_code_parse_stage.sv
// Self-checking bench for code_parse_stage with default parameters.
module tb_code_parse_stage;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_code = '0;
  logic        in_ready;
  logic        back_pressure;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_code;
  logic [1:0]  out_class;
  logic        out_illegal;
  logic        match_hit;
  logic [15:0] accept_cnt;

  int errors = 0;
  int checks = 0;

  // Behavioural reference state.
  logic [15:0] q[$];
  bit          m_ready = 0;
  bit          m_match = 0;
  int          m_cnt = 0;

  always #5 clk = ~clk;

  code_parse_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_code       (in_code),
    .in_ready      (in_ready),
    .back_pressure (back_pressure),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_code      (out_code),
    .out_class     (out_class),
    .out_illegal   (out_illegal),
    .match_hit     (match_hit),
    .accept_cnt    (accept_cnt)
  );

  // Classification from the opcode value ranges of a 4-bit opcode field.
  function automatic void ref_decode(input logic [15:0] c, output logic [1:0] cls,
                                     output logic ill);
    int opc;
    opc = int'(c) / 4096;
    ill = 1'b0;
    if (c == 16'h0000)  cls = 2'd0;
    else if (opc == 15) begin cls = 2'd0; ill = 1'b1; end
    else if (opc < 8)   cls = 2'd1;
    else if (opc < 12)  cls = 2'd2;
    else                cls = 2'd3;
  endfunction

  // One clock with the given inputs; advances the reference model.
  task automatic drive_cycle(input bit v, input logic [15:0] code, input bit rdy);
    bit push, pop;
    in_valid  = v;
    in_code   = code;
    out_ready = rdy;
    push = v && m_ready;
    pop  = rdy && (q.size() > 0);
    @(posedge clk); #1;
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(code);
    m_match = push && (code == 16'h0002);
    if (push && m_cnt < 65535) m_cnt++;
    m_ready = (q.size() < DEPTH);
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    q.delete(); m_ready = 0; m_match = 0; m_cnt = 0;
  endtask

  task automatic release_reset();
    rst = 1'b0;
    drive_cycle(0, 16'h0, 0);
  endtask

  task automatic test_reset();
    apply_reset(3);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (back_pressure !== 1'b1) begin errors++; $display("FAIL reset_bp got=%b exp=1", back_pressure); end
    checks++; if (match_hit !== 1'b0) begin errors++; $display("FAIL reset_match got=%b exp=0", match_hit); end
    checks++; if (accept_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got=%h exp=0", accept_cnt); end
    release_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    checks++; if (back_pressure !== 1'b0) begin errors++; $display("FAIL release_bp got=%b exp=0", back_pressure); end
  endtask

  task automatic test_match_first();
    drive_cycle(1, 16'h0002, 1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid got=%b exp=1", out_valid); end
    checks++; if (out_code !== 16'h0002) begin errors++; $display("FAIL first_code got=%h exp=0002", out_code); end
    checks++; if (out_class !== 2'd1) begin errors++; $display("FAIL first_class got=%0d exp=1", out_class); end
    checks++; if (match_hit !== 1'b1) begin errors++; $display("FAIL first_match got=%b exp=1", match_hit); end
    checks++; if (accept_cnt !== 16'd1) begin errors++; $display("FAIL first_cnt got=%0d exp=1", accept_cnt); end
    drive_cycle(0, 16'h0, 1);
    checks++; if (match_hit !== 1'b0) begin errors++; $display("FAIL match_pulse got=%b exp=0", match_hit); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL first_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_decode();
    logic [15:0] codes [4];
    logic [1:0]  cls_exp [4];
    logic        ill_exp [4];
    codes   = '{16'hF123, 16'h0000, 16'h8000, 16'hC000};
    cls_exp = '{2'd0, 2'd0, 2'd2, 2'd3};
    ill_exp = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1, codes[i], 1);
      checks++; if (out_code !== codes[i]) begin errors++; $display("FAIL dec_code[%0d] got=%h exp=%h", i, out_code, codes[i]); end
      checks++; if (out_class !== cls_exp[i]) begin errors++; $display("FAIL dec_class[%0d] got=%0d exp=%0d", i, out_class, cls_exp[i]); end
      checks++; if (out_illegal !== ill_exp[i]) begin errors++; $display("FAIL dec_illegal[%0d] got=%b exp=%b", i, out_illegal, ill_exp[i]); end
    end
    drive_cycle(0, 16'h0, 1);
  endtask

  task automatic test_fill_drain();
    logic [15:0] seq [5];
    int idx;
    bit sent5;
    seq = '{16'h1001, 16'h2002, 16'h3003, 16'h4004, 16'h5005};
    apply_reset(2);
    release_reset();
    for (int i = 0; i < 4; i++) drive_cycle(1, seq[i], 0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    checks++; if (back_pressure !== 1'b1) begin errors++; $display("FAIL full_bp got=%b exp=1", back_pressure); end
    drive_cycle(1, seq[4], 0);
    drive_cycle(1, seq[4], 0);
    checks++; if (accept_cnt !== 16'd4) begin errors++; $display("FAIL full_ignored_cnt got=%0d exp=4", accept_cnt); end
    idx = 0; sent5 = 0;
    for (int c = 0; c < 20 && idx < 5; c++) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (out_code !== seq[idx]) begin errors++; $display("FAIL drain_order[%0d] got=%h exp=%h", idx, out_code, seq[idx]); end
        idx++;
      end
      if (!sent5 && m_ready) begin
        drive_cycle(1, seq[4], 1);
        sent5 = 1;
      end else begin
        drive_cycle(sent5 ? 1'b0 : 1'b1, seq[4], 1);
      end
    end
    checks++; if (idx != 5) begin errors++; $display("FAIL drain_count got=%0d exp=5", idx); end
  endtask

  task automatic test_simul_push_pop();
    apply_reset(1);
    release_reset();
    drive_cycle(1, 16'h1111, 0);
    checks++; if (out_code !== 16'h1111) begin errors++; $display("FAIL pp_head0 got=%h exp=1111", out_code); end
    drive_cycle(1, 16'h2222, 1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pp_valid got=%b exp=1", out_valid); end
    checks++; if (out_code !== 16'h2222) begin errors++; $display("FAIL pp_head1 got=%h exp=2222", out_code); end
    drive_cycle(0, 16'h0, 1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pp_occ1 got=%b exp=0", out_valid); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1, 16'h0100 + 16'(i), 0);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    q.delete(); m_ready = 0; m_match = 0; m_cnt = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
    checks++; if (accept_cnt !== 16'h0) begin errors++; $display("FAIL midrst_cnt got=%0d exp=0", accept_cnt); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%b exp=0", in_ready); end
    release_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_release got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_random();
    logic [15:0] code;
    logic [1:0]  ecls;
    logic        eill;
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 5))
        0: code = 16'h0002;
        1: code = 16'h0000;
        2: code = 16'hF000 | 16'($urandom_range(0, 4095));
        default: code = 16'($urandom);
      endcase
      drive_cycle(($urandom_range(0, 3) != 0), code, ($urandom_range(0, 2) != 0));
      checks++; if (in_ready !== m_ready) begin errors++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, in_ready, m_ready); end
      checks++; if (back_pressure !== !m_ready) begin errors++; $display("FAIL rnd_bp c=%0d got=%b exp=%b", c, back_pressure, !m_ready); end
      checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, q.size() > 0); end
      checks++; if (match_hit !== m_match) begin errors++; $display("FAIL rnd_match c=%0d got=%b exp=%b", c, match_hit, m_match); end
      checks++; if (accept_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, accept_cnt, m_cnt); end
      if (q.size() > 0) begin
        ref_decode(q[0], ecls, eill);
        checks++; if (out_code !== q[0]) begin errors++; $display("FAIL rnd_code c=%0d got=%h exp=%h", c, out_code, q[0]); end
        checks++; if (out_class !== ecls) begin errors++; $display("FAIL rnd_class c=%0d got=%0d exp=%0d", c, out_class, ecls); end
        checks++; if (out_illegal !== eill) begin errors++; $display("FAIL rnd_illegal c=%0d got=%b exp=%b", c, out_illegal, eill); end
      end
    end
  endtask

  task automatic test_saturate();
    apply_reset(1);
    release_reset();
    for (int i = 0; i < 65540; i++) begin
      drive_cycle(1, 16'h1234, 1);
      if (i == 65533) begin
        checks++; if (accept_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got=%h exp=fffe", accept_cnt); end
      end
    end
    checks++; if (accept_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt got=%h exp=ffff", accept_cnt); end
    for (int i = 0; i < 3; i++) drive_cycle(1, 16'h0002, 1);
    checks++; if (accept_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h exp=ffff", accept_cnt); end
    checks++; if (match_hit !== 1'b1) begin errors++; $display("FAIL sat_match got=%b exp=1", match_hit); end
  endtask

  initial begin
    test_reset();
    test_match_first();
    test_decode();
    test_fill_drain();
    test_simul_push_pop();
    test_mid_reset();
    test_random();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_code_parse_stage

// File: doc/code_parse_stage.md
CODE_PARSE_STAGE -- requirements
Module: code_parse_stage

Interface
REQ-001 Parameter CODE_W, default 16, instruction code width; legal range 8..32.
REQ-002 Parameter OPC_W, default 4, opcode field width taken from code[CODE_W-1 -: OPC_W]; legal range 2..CODE_W-1.
REQ-003 Parameter DEPTH, default 4, entries in the parse FIFO; power of two, 2..16.
REQ-004 Parameter MATCH_CODE, default 16'h0002 zero-extended to CODE_W, code value that raises match_hit.
REQ-005 The block has one clock, clk; reset is rst, synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 in_valid  in  1  producer presents in_code.
REQ-009 in_code  in  CODE_W  instruction code from fetch.
REQ-010 in_ready  out  1  block can accept a code this cycle.
REQ-011 back_pressure  out  1  exactly ~in_ready.
REQ-012 out_valid  out  1  head entry is valid.
REQ-013 out_ready  in  1  consumer accepts the head entry.
REQ-014 out_code  out  CODE_W  head entry raw code.
REQ-015 out_class  out  2  head class: 0 NOP, 1 ALU, 2 LDST, 3 BRANCH.
REQ-016 out_illegal  out  1  head opcode is illegal.
REQ-017 match_hit  out  1  one-cycle pulse, accepted code equalled MATCH_CODE.
REQ-018 accept_cnt  out  16  saturating count of accepted codes.

Function
REQ-019 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-020 in_ready SHALL be 1 when occupancy < DEPTH and SHALL NOT depend on out_ready in the same cycle.
REQ-021 out_valid SHALL equal (occupancy != 0); out_* fields SHALL come directly from registered FIFO storage.
REQ-022 Latency: a code pushed in cycle N into an empty FIFO SHALL show out_valid=1 in cycle N+1.
REQ-023 Decode SHALL be computed at push time and stored with the code: code==0 -> NOP; opcode all ones -> class NOP and illegal=1; opcode MSB 0 -> ALU; opcode top bits 10 -> LDST; else BRANCH.
REQ-024 Output order SHALL equal push order, with no loss and no duplication.
REQ-025 Simultaneous push and pop SHALL leave occupancy unchanged, including when occupancy is 1.
REQ-026 When the FIFO is full, in_ready SHALL be 0 and in_valid SHALL be ignored.
REQ-027 When the FIFO is empty, out_ready SHALL be ignored.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 match_hit SHALL be 1 in cycle N+1 if and only if a push in cycle N carried in_code==MATCH_CODE.
REQ-030 accept_cnt SHALL increment by 1 per push and hold at 16'hFFFF.

Reset
REQ-031 While rst=1: occupancy=0, pointers=0, out_valid=0, in_ready=0, back_pressure=1, match_hit=0, accept_cnt=0.
REQ-032 In the first cycle after rst deasserts, in_ready SHALL be 1.
REQ-033 rst asserted mid-stream SHALL discard all queued entries; there SHALL be no pop output in the reset cycle.
REQ-034 FIFO storage data SHALL NOT require reset; out_code, out_class and out_illegal are don't-care while out_valid=0.

Structure
REQ-035 The shared package SHALL hold the class encodings (CLS_NOP, CLS_ALU, CLS_LDST, CLS_BR) and the default CODE_W and OPC_W.
REQ-036 The FIFO SHALL be a sub-module, parse_fifo, parametrised by width and DEPTH; decode, the match logic and the counter SHALL stay in code_parse_stage.

Verification
REQ-037 Reset, then push 16'h0002 with out_ready=1 -> next cycle: out_valid=1, out_code=16'h0002, class ALU, match_hit=1, accept_cnt=1.
REQ-038 Push 16'hF123 -> out_class=0 and out_illegal=1; push 16'h0000 -> class 0 and illegal=0; push 16'h8000 -> LDST; push 16'hC000 -> BRANCH.
REQ-039 Hold out_ready=0 and push 5 codes with DEPTH=4 -> in_ready=0 and back_pressure=1 after the 4th push; the 5th is held by the producer; the drain order is 1,2,3,4, then 5.
REQ-040 With occupancy 1, push and pop in the same cycle -> occupancy stays 1 and the new code becomes the head next cycle.
REQ-041 Assert rst with 3 entries queued -> next cycle out_valid=0 and accept_cnt=0; one cycle after release, in_ready=1.
REQ-042 Force 65540 pushes -> accept_cnt=16'hFFFF and holds there.
